frame_object_scheduler: RTL and testbench
=========================================

Name: frame_object_scheduler

Overview:
- Once-per-frame sequencer that computes the player sprite position and three horizontally patrolling enemy positions.
- Feeds the positions to the pixel painter and flags player/enemy collisions.
- Runs in the VGA clock domain and is triggered by a frame tick at the start of vertical blanking.
- New positions are computed in shadow registers and committed atomically, so the painter never sees a half-updated frame.

Parameters:
- X_MAX, 640, visible width in pixels.
- Y_MAX, 480, visible height in pixels.
- SPR_W, 32, player sprite width/height (square).
- EN_W, 32, enemy width/height (square).
- P_STEP, 4, player pixels per frame per pressed direction.
- E_STEP, 2, enemy pixels per frame.
- P_X0, 300, player reset X.
- P_Y0, 50, player reset Y.
- E_X0, 200, reset X of all enemies.
- E_Y0 / E_Y1 / E_Y2, 300 / 150 / 440, fixed enemy Y values.

Ports:
- clk  in  1  system/VGA clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse at vblank start.
- enable  in  1  0 = game paused (ticks ignored).
- btn  in  4  {up, down, left, right}, already debounced, level.
- posX, posY  out  10 each  committed player position.
- enX0, enX1, enX2  out  10 each  committed enemy X.
- enY0, enY1, enY2  out  10 each  constant enemy Y (E_Y*).
- collision  out  1  a collision was detected in the last committed frame.
- hit_count  out  8  saturating count of frames with a collision.
- busy  out  1  state != IDLE.
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - posX=P_X0, posY=P_Y0; enX*=E_X0.
  - Enemy direction bits: dir0=right, dir1=left, dir2=right.
  - collision=0, hit_count=0, busy=0, overrun=0, state=IDLE.
  - Shadow registers take the same values as the outputs.
  - Reset mid-sequence aborts with no commit.
- FSM states: IDLE, MOVE_P, MOVE_E0, MOVE_E1, MOVE_E2, CHECK, COMMIT.
- IDLE: accepted when frame_tick=1 && enable=1. btn is captured into a register, then state→MOVE_P. Otherwise stay in IDLE.
- Each subsequent state lasts exactly 1 cycle: MOVE_P→MOVE_E0→MOVE_E1→MOVE_E2→CHECK→COMMIT→IDLE.
- Latency: tick sampled at edge N → outputs update and state=IDLE at edge N+6. busy is high for cycles N+1..N+6 (6 cycles).
- MOVE_P, X axis (uses captured btn; arithmetic is 11-bit unsigned, no wrap):
  - left only: x = (x<P_STEP) ? 0 : x-P_STEP.
  - right only: x = min(x+P_STEP, X_MAX-SPR_W).
  - left and right both pressed, or neither: x unchanged.
- MOVE_P, Y axis: same rules with up (decrease) and down (increase), clamped to [0, Y_MAX-SPR_Y limit Y_MAX-SPR_W].
- MOVE_Ei, dir right: if x+E_STEP >= X_MAX-EN_W, then x=X_MAX-EN_W and dir=left; else x+=E_STEP.
- MOVE_Ei, dir left: if x <= E_STEP, then x=0 and dir=right; else x-=E_STEP.
- Direction change takes effect in the same frame the enemy hits the edge.
- CHECK: AABB overlap on the shadow positions, strict inequality (touching edges is not a hit). For each i:
  - px < ex+EN_W and ex < px+SPR_W, and
  - py < ey+EN_W and ey < py+SPR_W.
  - coll_pend = OR of the three results.
- COMMIT: copy all shadow positions to the outputs, collision=coll_pend. If coll_pend, hit_count+1, saturating at 255.
- frame_tick while busy: ignored, no queuing; overrun pulses for 1 cycle.
- frame_tick with enable=0 in IDLE: ignored, no overrun.
- Outputs hold their values between commits; enable=0 mid-sequence does not abort it.

Test Plan:
- Reset, then tick with btn=0: after 6 cycles posX=300, posY=50, enX0=202, enX1=198, enX2=202. busy high for exactly 6 cycles.
- posX=2, hold left, 1 tick: posX=0. Next tick: posX=0. Hold left and right: posX unchanged.
- Enemy0 at X=606, dir right, 1 tick: enX0=608, dir flips. Next tick: enX0=606.
- Move player to (200,300) overlapping enemy0: collision=1 and hit_count increments once per tick. At px=enX0+32: collision=0.
- 300 colliding frames: hit_count saturates at 255.
- Tick at N, second tick at N+3: overrun pulses once, only one update occurs. Assert rst at N+3: outputs return to reset values, no commit. Ticks with enable=0: no change.

Source files
------------

// File: rtl/frame_object_scheduler.sv
// Once-per-frame sprite sequencer: moves the player and three patrolling enemies in
// shadow registers, checks AABB overlap, then commits everything in one cycle.
module frame_object_scheduler #(
  parameter int X_MAX  = 640,
  parameter int Y_MAX  = 480,
  parameter int SPR_W  = 32,
  parameter int EN_W   = 32,
  parameter int P_STEP = 4,
  parameter int E_STEP = 2,
  parameter int P_X0   = 300,
  parameter int P_Y0   = 50,
  parameter int E_X0   = 200,
  parameter int E_Y0   = 300,
  parameter int E_Y1   = 150,
  parameter int E_Y2   = 440
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [3:0] btn,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic [9:0] enX0,
  output logic [9:0] enX1,
  output logic [9:0] enX2,
  output logic [9:0] enY0,
  output logic [9:0] enY1,
  output logic [9:0] enY2,
  output logic       collision,
  output logic [7:0] hit_count,
  output logic       busy,
  output logic       overrun
);
  localparam logic [10:0] PX_LIM = 11'(X_MAX - SPR_W);
  localparam logic [10:0] PY_LIM = 11'(Y_MAX - SPR_W);
  localparam logic [10:0] EX_LIM = 11'(X_MAX - EN_W);
  localparam logic [10:0] PS     = 11'(P_STEP);
  localparam logic [10:0] ES     = 11'(E_STEP);
  localparam logic [10:0] SW     = 11'(SPR_W);
  localparam logic [10:0] EW     = 11'(EN_W);

  typedef enum logic [2:0] {IDLE, MOVE_P, MOVE_E0, MOVE_E1, MOVE_E2, CHECK, COMMIT} state_t;
  state_t state, nstate;

  logic [3:0]       btn_q;
  logic [9:0]       sx, sy, nx, ny;
  logic [2:0][9:0]  se, ey, enx;
  logic [2:0]       sdir, endir, hit;
  logic             coll_pend;

  // btn = {up, down, left, right}; opposing presses cancel
  function automatic logic [9:0] axis_step(input logic [9:0] v, input logic dec,
                                           input logic inc, input logic [10:0] lim);
    logic [10:0] w, r;
    w = {1'b0, v};
    r = w;
    if (dec && !inc)      r = (w < PS) ? 11'd0 : w - PS;
    else if (inc && !dec) r = (w + PS > lim) ? lim : w + PS;
    return r[9:0];
  endfunction

  assign nx = axis_step(sx, btn_q[1], btn_q[0], PX_LIM);
  assign ny = axis_step(sy, btn_q[3], btn_q[2], PY_LIM);
  assign ey = {10'(E_Y2), 10'(E_Y1), 10'(E_Y0)};

  generate
    for (genvar i = 0; i < 3; i++) begin : g_en
      logic [10:0] ex, eyw;
      logic [9:0]  lnx;
      logic        ldir;
      assign ex  = {1'b0, se[i]};
      assign eyw = {1'b0, ey[i]};
      // sdir: 1 = moving right; bounce takes effect on the edge frame itself
      always_comb begin
        lnx  = se[i];
        ldir = sdir[i];
        if (sdir[i]) begin
          if (ex + ES >= EX_LIM) begin
            lnx  = EX_LIM[9:0];
            ldir = 1'b0;
          end else begin
            lnx = 10'(ex + ES);
          end
        end else begin
          if (ex <= ES) begin
            lnx  = 10'd0;
            ldir = 1'b1;
          end else begin
            lnx = 10'(ex - ES);
          end
        end
      end
      assign enx[i]   = lnx;
      assign endir[i] = ldir;
      // strict overlap: shared edges do not count
      assign hit[i] = ({1'b0, sx} < ex + EW) && (ex < {1'b0, sx} + SW) &&
                      ({1'b0, sy} < eyw + EW) && (eyw < {1'b0, sy} + SW);
    end
  endgenerate

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (frame_tick && enable) nstate = MOVE_P;
      MOVE_P:  nstate = MOVE_E0;
      MOVE_E0: nstate = MOVE_E1;
      MOVE_E1: nstate = MOVE_E2;
      MOVE_E2: nstate = CHECK;
      CHECK:   nstate = COMMIT;
      COMMIT:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign enY0 = ey[0];
  assign enY1 = ey[1];
  assign enY2 = ey[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      btn_q     <= '0;
      sx        <= 10'(P_X0);
      sy        <= 10'(P_Y0);
      se        <= {3{10'(E_X0)}};
      sdir      <= 3'b101;
      coll_pend <= 1'b0;
      posX      <= 10'(P_X0);
      posY      <= 10'(P_Y0);
      enX0      <= 10'(E_X0);
      enX1      <= 10'(E_X0);
      enX2      <= 10'(E_X0);
      collision <= 1'b0;
      hit_count <= '0;
      overrun   <= 1'b0;
    end else begin
      state   <= nstate;
      overrun <= frame_tick && busy;
      case (state)
        IDLE:    if (frame_tick && enable) btn_q <= btn;
        MOVE_P:  begin sx <= nx; sy <= ny; end
        MOVE_E0: begin se[0] <= enx[0]; sdir[0] <= endir[0]; end
        MOVE_E1: begin se[1] <= enx[1]; sdir[1] <= endir[1]; end
        MOVE_E2: begin se[2] <= enx[2]; sdir[2] <= endir[2]; end
        CHECK:   coll_pend <= |hit;
        COMMIT: begin
          posX      <= sx;
          posY      <= sy;
          enX0      <= se[0];
          enX1      <= se[1];
          enX2      <= se[2];
          collision <= coll_pend;
          if (coll_pend && hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_object_scheduler.sv
// Bench for frame_object_scheduler: frame-level model checked every cycle plus
// hand-computed checkpoints for clamps, bounces, collisions and overrun.
module tb_frame_object_scheduler;
  logic       clk = 0, rst = 1, frame_tick = 0, enable = 1;
  logic [3:0] btn = 0;
  logic [9:0] posX, posY, enX0, enX1, enX2, enY0, enY1, enY2;
  logic       collision, busy, overrun;
  logic [7:0] hit_count;

  frame_object_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable), .btn(btn),
    .posX(posX), .posY(posY), .enX0(enX0), .enX1(enX1), .enX2(enX2),
    .enY0(enY0), .enY1(enY1), .enY2(enY2), .collision(collision),
    .hit_count(hit_count), .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_L = 4'b0010, B_R = 4'b0001;

  int total = 0, bad = 0, ovr_cnt = 0, last_busy = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // frame-level model: a frame is accepted when idle, its result appears 6 edges later
  bit m_valid = 0;
  int cnt, m_px, m_py, m_hits, p_px, p_py;
  int m_ex[3], p_ex[3], m_dir[3];
  bit m_coll, p_coll, m_ovr;

  function automatic int ey_of(input int i);
    return (i == 0) ? 300 : (i == 1) ? 150 : 440;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin : model
    int nx, ny, e, nd;
    bit c;
    if (rst) begin
      m_valid <= 1; cnt <= 0; m_ovr <= 0;
      m_px <= 300; m_py <= 50; p_px <= 300; p_py <= 50;
      m_coll <= 0; p_coll <= 0; m_hits <= 0;
      for (int i = 0; i < 3; i++) begin
        m_ex[i] <= 200; p_ex[i] <= 200; m_dir[i] <= (i == 1) ? 0 : 1;
      end
    end else begin
      m_ovr <= (cnt != 0) && frame_tick;
      if (cnt == 0) begin
        if (frame_tick && enable) begin
          nx = p_px; ny = p_py;
          if (btn[1] && !btn[0]) nx = (nx - 4 < 0) ? 0 : nx - 4;
          if (btn[0] && !btn[1]) nx = (nx + 4 > 608) ? 608 : nx + 4;
          if (btn[3] && !btn[2]) ny = (ny - 4 < 0) ? 0 : ny - 4;
          if (btn[2] && !btn[3]) ny = (ny + 4 > 448) ? 448 : ny + 4;
          c = 0;
          for (int i = 0; i < 3; i++) begin
            e = p_ex[i]; nd = m_dir[i];
            if (nd == 1) begin
              if (e + 2 >= 608) begin e = 608; nd = 0; end else e = e + 2;
            end else begin
              if (e <= 2) begin e = 0; nd = 1; end else e = e - 2;
            end
            p_ex[i] <= e; m_dir[i] <= nd;
            if (iabs(nx - e) < 32 && iabs(ny - ey_of(i)) < 32) c = 1;
          end
          p_px <= nx; p_py <= ny; p_coll <= c;
          cnt <= 6;
        end
      end else begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          m_px <= p_px; m_py <= p_py; m_coll <= p_coll;
          for (int i = 0; i < 3; i++) m_ex[i] <= p_ex[i];
          if (p_coll && m_hits < 255) m_hits <= m_hits + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("posX", int'(posX), m_px);
      chk("posY", int'(posY), m_py);
      chk("enX0", int'(enX0), m_ex[0]);
      chk("enX1", int'(enX1), m_ex[1]);
      chk("enX2", int'(enX2), m_ex[2]);
      chk("enY0", int'(enY0), 300);
      chk("enY1", int'(enY1), 150);
      chk("enY2", int'(enY2), 440);
      chk("collision", int'(collision), int'(m_coll));
      chk("hit_count", int'(hit_count), m_hits);
      chk("busy", int'(busy), int'(cnt != 0));
      chk("overrun", int'(overrun), int'(m_ovr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (overrun) ovr_cnt++;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin step(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic frame(input logic [3:0] b);
    int n;
    btn = b; frame_tick = 1;
    step();
    frame_tick = 0;
    wait_idle(n);
    last_busy = n;
  endtask

  task automatic do_reset();
    rst = 1; frame_tick = 0; btn = 0;
    step(); step();
    rst = 0;
  endtask

  initial begin
    int n, o0;
    do_reset();
    chk("rst_posX", int'(posX), 300);
    chk("rst_posY", int'(posY), 50);
    chk("rst_enX0", int'(enX0), 200);
    chk("rst_hits", int'(hit_count), 0);
    chk("rst_busy", int'(busy), 0);

    frame(0);
    chk("f1_posX", int'(posX), 300);
    chk("f1_posY", int'(posY), 50);
    chk("f1_enX0", int'(enX0), 202);
    chk("f1_enX1", int'(enX1), 198);
    chk("f1_enX2", int'(enX2), 202);
    chk("f1_busy_cycles", last_busy, 6);

    // player clamps
    repeat (12) frame(B_UP);
    chk("py_2", int'(posY), 2);
    frame(B_UP);
    chk("py_clamp0", int'(posY), 0);
    frame(B_UP);
    chk("py_hold0", int'(posY), 0);
    repeat (75) frame(B_L);
    chk("px_0", int'(posX), 0);
    frame(B_L);
    chk("px_hold0", int'(posX), 0);
    frame(B_R);
    frame(B_L | B_R);
    chk("px_lr_cancel", int'(posX), 4);

    // overrun: second tick three edges after the first is dropped
    do_reset();
    o0 = ovr_cnt;
    btn = 0; frame_tick = 1; step();
    frame_tick = 0; step(); step();
    frame_tick = 1; step();
    frame_tick = 0;
    wait_idle(n);
    step(); step();
    chk("ovr_pulses", ovr_cnt - o0, 1);
    chk("ovr_enX0", int'(enX0), 202);

    // reset mid-sequence aborts, then paused ticks are ignored
    btn = B_R; frame_tick = 1; step();
    frame_tick = 0; step(); step();
    rst = 1; step();
    rst = 0; step();
    chk("abort_posX", int'(posX), 300);
    chk("abort_enX0", int'(enX0), 200);
    chk("abort_busy", int'(busy), 0);
    frame(0);
    chk("post_abort_enX0", int'(enX0), 202);
    chk("post_abort_enX1", int'(enX1), 198);
    enable = 0;
    o0 = ovr_cnt;
    repeat (3) begin frame_tick = 1; step(); frame_tick = 0; step(); end
    chk("paused_busy", int'(busy), 0);
    chk("paused_enX0", int'(enX0), 202);
    chk("paused_ovr", ovr_cnt - o0, 0);
    enable = 1;

    // collisions against enemy0 (y=300)
    do_reset();
    repeat (54) frame(B_DN);
    chk("c54_coll", int'(collision), 0);
    chk("c54_hits", int'(hit_count), 0);
    frame(B_DN);
    chk("c55_posY", int'(posY), 270);
    chk("c55_coll", int'(collision), 1);
    chk("c55_hits", int'(hit_count), 1);
    repeat (10) frame(0);
    chk("c65_enX0", int'(enX0), 330);
    chk("c65_hits", int'(hit_count), 11);
    frame(0);
    chk("c66_touch_enX0", int'(enX0), 332);
    chk("c66_touch_coll", int'(collision), 0);
    chk("c66_hits", int'(hit_count), 11);

    // chase enemy0 so every frame collides
    repeat (300) begin
      frame((m_px < m_ex[0]) ? B_R : (m_px > m_ex[0]) ? B_L : 4'b0000);
    end
    chk("sat_hits", int'(hit_count), 255);
    chk("sat_coll", int'(collision), 1);

    // enemy bounce at the right and left edges
    do_reset();
    repeat (203) frame(0);
    chk("e0_606", int'(enX0), 606);
    frame(0);
    chk("e0_608", int'(enX0), 608);
    frame(0);
    chk("e0_back606", int'(enX0), 606);
    chk("e1_after_bounce", int'(enX1), 210);

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 want=0");
    $fatal(1, "timeout");
  end
endmodule
